pixel_pack_writer: RTL

- Write-side feeder for the pixel frame RAM. The VGA path reads this RAM one byte per address.
- Accepts an 8-bit pixel stream with a valid/ready handshake and packs four pixels into each 32-bit write word.
- Drives the RAM write port (data, wraddress, wren) for one transfer of programmed length starting at a programmed base word address.
- Sits between the image-processing/loader logic and the RAM write port, replacing the top-level write pins.

---
 rtl/pixel_pack_writer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pixel_pack_writer.sv
// Packs an 8-bit valid/ready pixel stream into 32-bit words and drives the
// frame RAM write port for one transfer of programmed base address and length.
module pixel_pack_writer #(
  parameter int          ADDR_W   = 18,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic [31:0]       data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] words_written
);

  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word_q;
  logic [31:0]       word_next;
  logic              accept;
  logic              last_pix;
  logic              write_now;

  // Opening a new word pre-fills the upper lanes with PAD_BYTE, so a final
  // partial word is already padded when FLUSH writes it.
  function automatic logic [31:0] insert_byte(input logic [31:0] w,
                                              input logic [1:0]  l,
                                              input logic [7:0]  b);
    logic [31:0] r;
    if (l == 2'd0) begin
      r = {PAD_BYTE, PAD_BYTE, PAD_BYTE, b};
    end else begin
      r = w;
      r[{l, 3'b000} +: 8] = b;
    end
    return r;
  endfunction

  always_comb begin
    accept     = (state == PACK) && pix_ready && pix_valid;
    last_pix   = accept && ((cnt + ADDR_W'(1)) == len_q);
    write_now  = (accept && (lane == 2'd3)) || (state == FLUSH);
    word_next  = insert_byte(word_q, lane, pix_data);
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (length == '0) ? DONE : PACK;
        end
      end
      PACK: begin
        if (last_pix) begin
          state_next = (lane == 2'd3) ? DONE : FLUSH;
        end
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs and datapath; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_ready     <= 1'b0;
      data          <= '0;
      wraddress     <= '0;
      wren          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
      lane          <= 2'd0;
      cnt           <= '0;
    end else begin
      pix_ready <= (state_next == PACK);
      busy      <= (state_next != IDLE);
      done      <= (state == DONE);
      wren      <= write_now;

      if ((state == IDLE) && start) begin
        addr_q        <= base_addr;
        len_q         <= length;
        words_written <= '0;
        cnt           <= '0;
        lane          <= 2'd0;
      end

      if (accept) begin
        word_q <= word_next;
        lane   <= lane + 2'd1;
        cnt    <= cnt + ADDR_W'(1);
      end

      if (write_now) begin
        data          <= (state == FLUSH) ? word_q : word_next;
        wraddress     <= addr_q;
        addr_q        <= addr_q + ADDR_W'(1);
        words_written <= words_written + ADDR_W'(1);
      end
    end
  end

endmodule
